// File: rtl/hex_page_source.sv
// Feeds four hex decoders with paged snapshots of processor state.
// The page is stepped by a synchronized, debounced push-button.
module hex_page_source #(
  parameter int DB_CYCLES = 500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Strobe,
  input  logic        Freeze,
  input  logic        PageBtn_n,
  input  logic [15:0] IR,
  input  logic [7:0]  PC,
  input  logic [3:0]  State,
  input  logic [15:0] ALU_A,
  input  logic [15:0] Result,
  output logic [3:0]  N3,
  output logic [3:0]  N2,
  output logic [3:0]  N1,
  output logic [3:0]  N0,
  output logic [1:0]  Page,
  output logic [7:0]  SnapCount
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [15:0]   snap_ir;
  logic [7:0]    snap_pc;
  logic [3:0]    snap_state;
  logic [15:0]   snap_alu_a;
  logic [15:0]   snap_result;
  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] db_count;
  logic          press;
  logic [15:0]   page_word;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      snap_ir     <= '0;
      snap_pc     <= '0;
      snap_state  <= '0;
      snap_alu_a  <= '0;
      snap_result <= '0;
      SnapCount   <= '0;
    end else if (Strobe && !Freeze) begin
      snap_ir     <= IR;
      snap_pc     <= PC;
      snap_state  <= State;
      snap_alu_a  <= ALU_A;
      snap_result <= Result;
      SnapCount   <= SnapCount + 8'd1;
    end
  end

  // Synchronizer and debouncer idle at the released (high) level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      db_count <= '0;
    end else begin
      sync1    <= PageBtn_n;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 != stable) begin
        if (db_count == DB_LAST) begin
          stable   <= sync2;
          db_count <= '0;
        end else begin
          db_count <= db_count + 1'b1;
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  // Only the falling edge of the debounced level (a press) steps the page.
  assign press = stable_d & ~stable;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Page <= '0;
    end else if (press) begin
      Page <= Page + 2'd1;
    end
  end

  always_comb begin
    page_word = snap_ir;
    case (Page)
      2'd0: page_word = snap_ir;
      2'd1: page_word = {snap_pc, 4'h0, snap_state};
      2'd2: page_word = snap_alu_a;
      2'd3: page_word = snap_result;
      default: page_word = snap_ir;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      N3 <= '0;
      N2 <= '0;
      N1 <= '0;
      N0 <= '0;
    end else begin
      N3 <= page_word[15:12];
      N2 <= page_word[11:8];
      N1 <= page_word[7:4];
      N0 <= page_word[3:0];
    end
  end

endmodule

// File: tb/tb_hex_page_source.sv
// Self-checking bench for hex_page_source: directed scenarios plus random
// traffic, all compared every cycle against a behavioural model.
module tb_hex_page_source;

  localparam int DB = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Strobe = 1'b0;
  logic        Freeze = 1'b0;
  logic        PageBtn_n = 1'b1;
  logic [15:0] IR = '0;
  logic [7:0]  PC = '0;
  logic [3:0]  State = '0;
  logic [15:0] ALU_A = '0;
  logic [15:0] Result = '0;
  logic [3:0]  N3, N2, N1, N0;
  logic [1:0]  Page;
  logic [7:0]  SnapCount;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 0;

  hex_page_source #(.DB_CYCLES(DB)) dut (
    .Clk(Clk), .Reset(Reset), .Strobe(Strobe), .Freeze(Freeze),
    .PageBtn_n(PageBtn_n), .IR(IR), .PC(PC), .State(State),
    .ALU_A(ALU_A), .Result(Result), .N3(N3), .N2(N2), .N1(N1), .N0(N0),
    .Page(Page), .SnapCount(SnapCount)
  );

  always #5 Clk = ~Clk;

  // Behavioural model state
  logic [15:0] m_ir, m_alu_a, m_result;
  logic [7:0]  m_pc, m_count;
  logic [3:0]  m_state;
  logic [1:0]  m_page;
  logic [15:0] m_nib;
  logic        m_raw1, m_raw2, m_stable;
  bit          m_press_pending;
  bit          synced_hist[$];

  function automatic logic [15:0] page_value(input logic [1:0] pg);
    case (pg)
      2'd0: return m_ir;
      2'd1: return {m_pc, 4'h0, m_state};
      2'd2: return m_alu_a;
      default: return m_result;
    endcase
  endfunction

  function automatic bit all_differ();
    if (synced_hist.size() < DB) return 0;
    foreach (synced_hist[i]) if (synced_hist[i] == m_stable) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_ir = '0; m_pc = '0; m_state = '0; m_alu_a = '0; m_result = '0;
    m_count = '0; m_page = '0; m_nib = '0;
    m_raw1 = 1'b1; m_raw2 = 1'b1; m_stable = 1'b1;
    m_press_pending = 0;
    synced_hist.delete();
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      model_reset();
    end else begin
      bit synced;
      m_nib = page_value(m_page);
      if (m_press_pending) m_page = m_page + 2'd1;
      if (Strobe && !Freeze) begin
        m_ir = IR; m_pc = PC; m_state = State; m_alu_a = ALU_A; m_result = Result;
        m_count = m_count + 8'd1;
      end
      synced = m_raw2;
      m_raw2 = m_raw1;
      m_raw1 = PageBtn_n;
      synced_hist.push_back(synced);
      if (synced_hist.size() > DB) void'(synced_hist.pop_front());
      m_press_pending = 0;
      if (all_differ()) begin
        if (m_stable) m_press_pending = 1;
        m_stable = ~m_stable;
        synced_hist.delete();
      end
    end
  end

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge Clk) begin
    #2;
    if (check_en) begin
      check_output("nibbles", {N3, N2, N1, N0}, m_nib);
      check_output("page", {14'd0, Page}, {14'd0, m_page});
      check_output("snapcount", {8'd0, SnapCount}, {8'd0, m_count});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic apply_stimulus(input int cycles_low, input int cycles_high);
    PageBtn_n = 1'b0;
    tick(cycles_low);
    PageBtn_n = 1'b1;
    tick(cycles_high);
  endtask

  task automatic strobe_once();
    Strobe = 1'b1;
    tick(1);
    Strobe = 1'b0;
  endtask

  initial begin
    model_reset();
    tick(3);
    Reset = 1'b0;
    check_en = 1;
    tick(1);

    // Snapshot onto page 0
    IR = 16'hA5C3;
    strobe_once();
    tick(1);
    check_output("page0 A5C3", {N3, N2, N1, N0}, 16'hA5C3);
    check_output("count 1", {8'd0, SnapCount}, 16'd1);

    // Page through all four views
    PC = 8'h3E; State = 4'h7; ALU_A = 16'h1234; Result = 16'hBEEF;
    strobe_once();
    tick(2);
    apply_stimulus(20, 20);
    check_output("page1 3E07", {N3, N2, N1, N0}, 16'h3E07);
    check_output("page index 1", {14'd0, Page}, 16'd1);
    apply_stimulus(20, 20);
    check_output("page2 1234", {N3, N2, N1, N0}, 16'h1234);
    apply_stimulus(20, 20);
    check_output("page3 BEEF", {N3, N2, N1, N0}, 16'hBEEF);
    apply_stimulus(20, 20);
    check_output("page0 again", {N3, N2, N1, N0}, 16'hA5C3);
    check_output("page index 0", {14'd0, Page}, 16'd0);

    // Bounce rejection
    for (int i = 0; i < 15; i++) begin
      PageBtn_n = ~PageBtn_n;
      tick(2);
    end
    PageBtn_n = 1'b1;
    tick(12);
    check_output("bounce page", {14'd0, Page}, 16'd0);

    // Freeze
    IR = 16'h1111;
    strobe_once();
    tick(2);
    check_output("pre-freeze", {N3, N2, N1, N0}, 16'h1111);
    Freeze = 1'b1;
    IR = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      strobe_once();
      tick(1);
    end
    tick(1);
    check_output("frozen display", {N3, N2, N1, N0}, 16'h1111);
    check_output("frozen count", {8'd0, SnapCount}, 16'd3);
    Freeze = 1'b0;
    strobe_once();
    tick(2);
    check_output("unfrozen", {N3, N2, N1, N0}, 16'h2222);
    check_output("count 4", {8'd0, SnapCount}, 16'd4);

    // Reset mid-debounce, checked without any clock edge
    PageBtn_n = 1'b0;
    tick(3);
    Reset = 1'b1;
    #1;
    check_output("reset nibbles", {N3, N2, N1, N0}, 16'h0000);
    check_output("reset page", {14'd0, Page}, 16'd0);
    check_output("reset count", {8'd0, SnapCount}, 16'd0);
    PageBtn_n = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(2);

    // 256 consecutive strobes wrap the counter
    Strobe = 1'b1;
    tick(256);
    Strobe = 1'b0;
    tick(1);
    check_output("wrap count", {8'd0, SnapCount}, 16'd0);

    // Strobe coincident with the advance pulse
    PC = 8'h5A; State = 4'h9;
    PageBtn_n = 1'b0;
    begin
      int budget = 50;
      while (!m_press_pending && budget > 0) begin
        tick(1);
        budget--;
      end
      if (budget == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL press timeout: got none expected press within 50 cycles");
      end
    end
    strobe_once();
    tick(1);
    check_output("simul page", {14'd0, Page}, 16'd1);
    check_output("simul data", {N3, N2, N1, N0}, 16'h5A09);
    PageBtn_n = 1'b1;
    tick(10);

    // Random traffic
    begin
      int btn_left = 0;
      for (int c = 0; c < 3000; c++) begin
        Strobe = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 19) == 0) Freeze = ~Freeze;
        IR = 16'($urandom); PC = 8'($urandom); State = 4'($urandom);
        ALU_A = 16'($urandom); Result = 16'($urandom);
        if (btn_left == 0) begin
          PageBtn_n = 1'($urandom_range(0, 1));
          btn_left = $urandom_range(1, 12);
        end
        btn_left--;
        if (c == 1500) Reset = 1'b1;
        if (c == 1503) Reset = 1'b0;
        tick(1);
      end
    end
    Strobe = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_page_source.md
# hex_page_source

Upstream feeder for the four seven-segment hex decoders on the processor board. It snapshots processor state (IR, PC, control-unit state, ALU operand A, ALU result) on each commit strobe. It lets the user page through the snapshots with a debounced push-button and drives four registered 4-bit nibbles, one per decoder. A freeze switch holds the current snapshot so a program can be inspected while it keeps running.

## Interface

- DB_CYCLES, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Strobe  in  1  single-cycle commit pulse from the control unit; snapshot enable.
- Freeze  in  1  level; while high, Strobe is ignored.
- PageBtn_n  in  1  raw active-low push-button, asynchronous to Clk.
- IR  in  16  instruction register.
- PC  in  8  program counter.
- State  in  4  control-unit state code.
- ALU_A  in  16  ALU operand A.
- Result  in  16  ALU result.
- N3, N2, N1, N0  out  4 each  nibbles to decoders; N3 is the most significant digit.
- Page  out  2  currently displayed page.
- SnapCount  out  8  number of accepted snapshots, wraps 255 to 0.

## Operation

- Snapshot: on a rising edge with Strobe=1 and Freeze=0, load IR, PC, State, ALU_A and Result into internal snapshot registers, and increment SnapCount modulo 256. With Freeze=1, snapshots and SnapCount hold.
- Button path: a 2-FF synchronizer feeds the debouncer. The debouncer keeps a stable level, reset to 1 (released), and a counter. When the synced input differs from the stable level, the counter increments. When the synced input equals the stable level, the counter clears. When the counter reaches DB_CYCLES-1 while still differing, the stable level flips and the counter clears.
- Page advance: a one-cycle pulse fires when the stable level goes 1 to 0 (press). Page increments 0, 1, 2, 3, 0. A release generates no advance. A held button advances exactly once.
- Page contents, N3..N0:
  - page 0: IR[15:0].
  - page 1: PC[7:4], PC[3:0], 4'h0, State.
  - page 2: ALU_A[15:0].
  - page 3: Result[15:0].
- Nibble outputs are registered from the page multiplexer over the snapshot registers and the current Page.
- Reset values: snapshots 0, SnapCount 0, Page 0, N3..N0 0, debounce counter 0, stable level 1, synchronizer flops 1.
- Reset asserted mid-debounce or mid-snapshot discards partial state; nothing carries over.

## Timing

- Snapshot latency: Strobe sampled at edge k updates the snapshot at edge k. Nibbles show the new data after edge k+1.
- Page latency: the press is accepted at edge p (stable level flips) and the advance pulse is registered at p+1. Page updates at p+1 and nibbles update at p+2.
- Button latency: 2 synchronizer cycles plus DB_CYCLES cycles from a clean level change to the stable-level flip.
- Glitches shorter than DB_CYCLES cycles produce no level change and no advance.
- Simultaneous Strobe and page advance in the same cycle: both take effect. The next nibble update shows the new page with the new snapshot.
- Strobe held high for several cycles: a snapshot is taken every cycle and SnapCount increments every cycle. The control unit guarantees single-cycle pulses, but the block does not edge-detect.
- Freeze toggles in the same cycle as Strobe: the Freeze value sampled at that edge decides.

## Test plan

- Reset: assert Reset mid-run, then release. All outputs read 0, Page=0, SnapCount=0. There is no Clk dependency while Reset=1.
- Snapshot/page 0: IR=16'hA5C3, pulse Strobe. Two edges later N3..N0 = A,5,C,3 and SnapCount=1.
- Paging, DB_CYCLES=4: press, hold 20 cycles, release, repeated 4 times, with PC=8'h3E, State=4'h7, ALU_A=16'h1234, Result=16'hBEEF snapped. The bench sees:
  - page 1: 3,E,0,7.
  - page 2: 1,2,3,4.
  - page 3: B,E,E,F.
  - then page 0, exactly one advance per press.
- Bounce rejection, DB_CYCLES=4: toggle PageBtn_n every 2 cycles for 30 cycles, then hold high. Page is unchanged.
- Freeze: snapshot IR=16'h1111, set Freeze=1, then IR=16'h2222 with 3 Strobes. Display stays 1,1,1,1 and SnapCount is unchanged. Clear Freeze and strobe once: display shows 2,2,2,2.
- Wrap and simultaneous events: 256 Strobes give SnapCount=0. A Strobe coinciding with the advance pulse shows the new page with the new data at the next nibble update.
